vend_sequencer: RTL and testbench

Sequencing controller for the 6 CNY vending datapath. It accepts asynchronous-arrival coin pulses from the 1/2/5 CNY acceptors and serialises them into a credit register. When credit reaches the price it issues a single vend strobe, then pays out change one coin at a time over a req/ack handshake to the change hopper. It sits between the coin acceptors and the product/change actuators and owns all credit bookkeeping.

---
 rtl/vend_pkg.sv | 32 +++
 rtl/vend_coin_queue.sv | 52 +++++
 rtl/vend_sequencer.sv | 124 ++++++++++++
 tb/tb_vend_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending sequencer: FSM encoding, coin denominations
// and the default product price.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } state_e;

  localparam int unsigned COIN_1_VAL    = 1;
  localparam int unsigned COIN_2_VAL    = 2;
  localparam int unsigned COIN_5_VAL    = 5;
  localparam int unsigned DEFAULT_PRICE = 6;

  // Width of a coin value (0/1/2/5) and bit positions in the pending latch.
  localparam int unsigned COIN_W = 3;
  localparam int unsigned IDX_1  = 0;
  localparam int unsigned IDX_2  = 1;
  localparam int unsigned IDX_5  = 2;

  function automatic logic [COIN_W-1:0] coin_value(input logic [2:0] sel);
    logic [COIN_W-1:0] v;
    v = '0;
    if (sel[IDX_5])      v = COIN_W'(COIN_5_VAL);
    else if (sel[IDX_2]) v = COIN_W'(COIN_2_VAL);
    else if (sel[IDX_1]) v = COIN_W'(COIN_1_VAL);
    return v;
  endfunction

endpackage

// File: rtl/vend_coin_queue.sv
// Pending-coin latch: captures acceptor pulses, offers the highest pending
// denomination to the sequencer and flags coins that arrive on an occupied slot.
module vend_coin_queue
  import vend_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              coin_1_i,
  input  logic              coin_2_i,
  input  logic              coin_5_i,
  input  logic              take_i,
  output logic [COIN_W-1:0] coin_val_o,
  output logic              reject_o
);

  logic [2:0] pend_q, pend_d;
  logic       reject_q, reject_d;
  logic [2:0] sel_oh;
  logic [2:0] consume;
  logic [2:0] arrive;

  assign arrive = {coin_5_i, coin_2_i, coin_1_i};

  always_comb begin
    sel_oh = 3'b000;
    if (pend_q[IDX_5])      sel_oh[IDX_5] = 1'b1;
    else if (pend_q[IDX_2]) sel_oh[IDX_2] = 1'b1;
    else if (pend_q[IDX_1]) sel_oh[IDX_1] = 1'b1;
  end

  // A fresh pulse on a slot being consumed re-arms it, so only an occupied,
  // unconsumed slot drops the coin.
  always_comb begin
    consume  = take_i ? sel_oh : 3'b000;
    pend_d   = (pend_q & ~consume) | arrive;
    reject_d = |(arrive & pend_q & ~consume);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q   <= 3'b000;
      reject_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      reject_q <= reject_d;
    end
  end

  assign coin_val_o = coin_value(sel_oh);
  assign reject_o   = reject_q;

endmodule

// File: rtl/vend_sequencer.sv
// Vending sequencer: credits pending coins, issues the vend strobe at price and
// pays out change one coin per hopper handshake.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int unsigned PRICE    = DEFAULT_PRICE,
  parameter int unsigned CREDIT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_coin_1,
  input  logic                i_coin_2,
  input  logic                i_coin_5,
  input  logic                i_cancel,
  input  logic                i_chg_ack,
  output logic                o_vend,
  output logic                o_chg_req,
  output logic                o_chg_two,
  output logic                o_reject,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_busy
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] TWO_C   = CREDIT_W'(COIN_2_VAL);
  localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(COIN_1_VAL);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                take;
  logic [COIN_W-1:0]   coin_val;
  logic [CREDIT_W-1:0] coin_ext;
  logic                at_price;

  function automatic logic [CREDIT_W-1:0] change_step(input logic [CREDIT_W-1:0] c);
    return (c >= TWO_C) ? TWO_C : ONE_C;
  endfunction

  vend_coin_queue u_queue (
    .clk        (clk),
    .rst        (rst),
    .coin_1_i   (i_coin_1),
    .coin_2_i   (i_coin_2),
    .coin_5_i   (i_coin_5),
    .take_i     (take),
    .coin_val_o (coin_val),
    .reject_o   (o_reject)
  );

  assign coin_ext = CREDIT_W'(coin_val);
  assign at_price = (credit_q >= PRICE_C);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    take     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        take = 1'b1;
        if (coin_val != '0) begin
          credit_d = credit_q + coin_ext;
          state_d  = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        // Reaching the price beats a simultaneous cancel.
        if (at_price) begin
          state_d = ST_VEND;
        end else if (i_cancel) begin
          state_d = ST_CHANGE;
        end else begin
          take = 1'b1;
          if (coin_val != '0) credit_d = credit_q + coin_ext;
        end
      end
      ST_VEND: begin
        credit_d = credit_q - PRICE_C;
        state_d  = (credit_d != '0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        if (i_chg_ack) begin
          credit_d = credit_q - change_step(credit_q);
          if (credit_d == '0) state_d = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
      end
    endcase
  end

  always_comb begin
    o_vend    = 1'b0;
    o_chg_req = 1'b0;
    o_chg_two = 1'b0;
    o_busy    = 1'b0;
    case (state_q)
      ST_VEND: begin
        o_vend = 1'b1;
        o_busy = 1'b1;
      end
      ST_CHANGE: begin
        o_chg_req = 1'b1;
        o_chg_two = (credit_q >= TWO_C);
        o_busy    = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_credit = credit_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: table-driven purchase vectors plus hand-written
// corner sequences, with vend/change/reject events checked against a queue.
module tb_vend_sequencer;

  localparam int CREDIT_W = 4;

  logic                clk;
  logic                rst;
  logic                i_coin_1, i_coin_2, i_coin_5, i_cancel, i_chg_ack;
  logic                o_vend, o_chg_req, o_chg_two, o_reject, o_busy;
  logic [CREDIT_W-1:0] o_credit;

  vend_sequencer #(.PRICE(6), .CREDIT_W(CREDIT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_coin_1  (i_coin_1),
    .i_coin_2  (i_coin_2),
    .i_coin_5  (i_coin_5),
    .i_cancel  (i_cancel),
    .i_chg_ack (i_chg_ack),
    .o_vend    (o_vend),
    .o_chg_req (o_chg_req),
    .o_chg_two (o_chg_two),
    .o_reject  (o_reject),
    .o_credit  (o_credit),
    .o_busy    (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event codes: 1 vend, 2 change 1 CNY, 3 change 2 CNY, 4 reject.
  typedef struct {
    string       nm;
    logic        c5, c2, c1, cancel;
    int          gap;
    int          exp_credit;
    logic        exp_busy;
    logic [31:0] ev;
  } vec_t;

  vec_t tbl[8];
  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];
  int   ack_delays[$];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic push_ev(input logic [31:0] ev);
    for (int i = 0; i < 8; i++) begin
      int n;
      n = int'(ev[4*i +: 4]);
      if (n == 0) break;
      exp_q.push_back(n);
    end
  endtask

  task automatic note_ev(input int code);
    int e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event actual=%0d required=none", code);
    end else begin
      e = exp_q.pop_front();
      if (e != code) begin
        errors++;
        $display("FAIL event_order actual=%0d required=%0d", code, e);
      end
    end
  endtask

  task automatic wait_req(input string nm, input int limit);
    int n;
    n = 0;
    while (!o_chg_req && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(nm, int'(o_chg_req), 1);
  endtask

  task automatic wait_idle(input string nm, input int cred, input int limit);
    int n;
    n = 0;
    while (!(!o_busy && int'(o_credit) == cred) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_credit"}, int'(o_credit), cred);
    check({nm, "_busy"}, int'(o_busy), 0);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(nm, exp_q.size(), 0);
  endtask

  task automatic check_all_low(input string nm);
    check({nm, "_vend"}, int'(o_vend), 0);
    check({nm, "_chg_req"}, int'(o_chg_req), 0);
    check({nm, "_chg_two"}, int'(o_chg_two), 0);
    check({nm, "_reject"}, int'(o_reject), 0);
    check({nm, "_busy"}, int'(o_busy), 0);
    check({nm, "_credit"}, int'(o_credit), 0);
  endtask

  // Hopper model and event monitor share the negedge so acks and event records agree.
  initial begin
    int wait_cnt;
    int d;
    wait_cnt  = 0;
    i_chg_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        i_chg_ack = 1'b0;
        wait_cnt  = 0;
        ack_delays.delete();
      end else begin
        if (o_vend)   note_ev(1);
        if (o_reject) note_ev(4);
        if (o_chg_req) begin
          d = (ack_delays.size() > 0) ? ack_delays[0] : 0;
          if (wait_cnt >= d) begin
            i_chg_ack = 1'b1;
            wait_cnt  = 0;
            if (ack_delays.size() > 0) void'(ack_delays.pop_front());
            note_ev(o_chg_two ? 3 : 2);
          end else begin
            i_chg_ack = 1'b0;
            wait_cnt++;
          end
        end else begin
          i_chg_ack = 1'b0;
          wait_cnt  = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    i_coin_1 = 1'b0;
    i_coin_2 = 1'b0;
    i_coin_5 = 1'b0;
    i_cancel = 1'b0;

    tbl[0] = '{"five",       1'b1, 1'b0, 1'b0, 1'b0, 1, 5, 1'b0, 32'h0};
    tbl[1] = '{"one_vend",   1'b0, 1'b0, 1'b1, 1'b0, 1, 6, 1'b0, 32'h1};
    tbl[2] = '{"idle_after", 1'b0, 1'b0, 1'b0, 1'b0, 3, 0, 1'b0, 32'h0};
    tbl[3] = '{"two_a",      1'b0, 1'b1, 1'b0, 1'b0, 1, 2, 1'b0, 32'h0};
    tbl[4] = '{"two_b",      1'b0, 1'b1, 1'b0, 1'b0, 1, 4, 1'b0, 32'h0};
    tbl[5] = '{"cancel",     1'b0, 1'b0, 1'b0, 1'b1, 3, 0, 1'b0, 32'h33};
    tbl[6] = '{"all_three",  1'b1, 1'b1, 1'b1, 1'b0, 6, 1, 1'b0, 32'h21};
    tbl[7] = '{"cancel_one", 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 32'h2};

    repeat (3) @(negedge clk);
    check_all_low("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      push_ev(tbl[i].ev);
      @(negedge clk);
      i_coin_5 = tbl[i].c5;
      i_coin_2 = tbl[i].c2;
      i_coin_1 = tbl[i].c1;
      i_cancel = tbl[i].cancel;
      @(negedge clk);
      i_coin_5 = 1'b0;
      i_coin_2 = 1'b0;
      i_coin_1 = 1'b0;
      i_cancel = 1'b0;
      repeat (tbl[i].gap) @(negedge clk);
      check({tbl[i].nm, "_credit"}, int'(o_credit), tbl[i].exp_credit);
      check({tbl[i].nm, "_busy"}, int'(o_busy), int'(tbl[i].exp_busy));
    end
    drain("table_drain");

    // Two fives on consecutive cycles; the second re-arms the slot being consumed.
    push_ev(32'h331);
    ack_delays.push_back(0);
    ack_delays.push_back(3);
    @(negedge clk);
    i_coin_5 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i_coin_5 = 1'b0;
    @(negedge clk);
    check("dbl5_credit10", int'(o_credit), 10);
    @(negedge clk);
    check("dbl5_busy_vend", int'(o_busy), 1);
    @(negedge clk);
    check("dbl5_rem", int'(o_credit), 4);
    check("dbl5_two_a", int'(o_chg_two), 1);
    @(negedge clk);
    check("dbl5_rem2", int'(o_credit), 2);
    check("dbl5_two_b", int'(o_chg_two), 1);
    check("dbl5_req_held", int'(o_chg_req), 1);
    wait_idle("dbl5_end", 0, 20);
    drain("dbl5_drain");

    // Duplicate 2 CNY while the latch is stalled by a slow hopper.
    push_ev(32'h1);
    ack_delays.push_back(10);
    @(negedge clk);
    i_coin_5 = 1'b1;
    @(negedge clk);
    i_coin_5 = 1'b0;
    i_coin_2 = 1'b1;
    @(negedge clk);
    i_coin_2 = 1'b0;
    wait_req("dup_req", 20);
    check("dup_rem", int'(o_credit), 1);
    check("dup_two", int'(o_chg_two), 0);
    @(negedge clk);
    i_coin_2 = 1'b1;
    @(negedge clk);
    i_coin_2 = 1'b0;
    @(negedge clk);
    push_ev(32'h24);
    i_coin_2 = 1'b1;
    @(negedge clk);
    i_coin_2 = 1'b0;
    check("dup_reject", int'(o_reject), 1);
    check("dup_credit_kept", int'(o_credit), 1);
    wait_idle("dup_pending", 2, 40);
    push_ev(32'h3);
    @(negedge clk);
    i_cancel = 1'b1;
    @(negedge clk);
    i_cancel = 1'b0;
    wait_idle("dup_refund", 0, 20);
    drain("dup_drain");

    // Reset while paying out a credit of 3.
    push_ev(32'h1);
    ack_delays.push_back(20);
    @(negedge clk);
    i_coin_2 = 1'b1;
    @(negedge clk);
    i_coin_2 = 1'b0;
    repeat (2) @(negedge clk);
    i_coin_2 = 1'b1;
    @(negedge clk);
    i_coin_2 = 1'b0;
    repeat (2) @(negedge clk);
    i_coin_5 = 1'b1;
    @(negedge clk);
    i_coin_5 = 1'b0;
    wait_req("rst_req", 20);
    check("rst_pre_credit", int'(o_credit), 3);
    check("rst_pre_two", int'(o_chg_two), 1);
    drain("rst_vend_drain");
    rst = 1'b0;
    #1;
    check_all_low("rst_async");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_after_credit", int'(o_credit), 0);
    check("rst_after_busy", int'(o_busy), 0);
    check("rst_after_req", int'(o_chg_req), 0);
    drain("final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
